mux_nx1_rr_reg: RTL and testbench

- Parametrised, registered N:1 result-select stage for the pipelined core.
- Picks one of NUM_IN source channels and delivers it through a valid/ready output register. Typical sources: ALU, load unit, PC+4, CSR.
- Two select modes: explicit select (writeback-mux style), or round-robin arbitration among valid channels.
- Sits between the execute/memory units and the writeback register-file port.

---
 rtl/mux_nx1_rr_reg.sv | 193 +++++++++++++++++++
 tb/tb_mux_nx1_rr_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_rr_reg.sv
// mux_nx1_rr_reg: registered N:1 result select, explicit or round-robin grant.
// Define MUX_NX1_SKID_EN to add a 2-entry output skid buffer.
module mux_nx1_rr_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_IN     = 4,
    parameter int SEL_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_IN-1:0]            i_valid,
    output logic [NUM_IN-1:0]            o_ready,
    input  logic                         i_mode,
    input  logic [SEL_W-1:0]             i_Sel,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [SEL_W-1:0]             o_src,
    output logic                         o_sel_err
);

    logic [DATA_WIDTH-1:0] chan [NUM_IN];

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]      src_q, src_d;
    logic                  valid_q, valid_d;
    logic                  sel_err_q, sel_err_d;
    logic [SEL_W-1:0]      rr_q, rr_d;

    logic                  sel_ok;
    logic                  sel_hit;
    logic                  rr_gnt_vld;
    logic [SEL_W-1:0]      rr_gnt;
    logic                  gnt_vld;
    logic [SEL_W-1:0]      gnt;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  load_en;
    logic                  xfer;

`ifdef MUX_NX1_SKID_EN
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0]      skid_src_q, skid_src_d;
    logic                  skid_vld_q, skid_vld_d;
    logic                  pop;
`endif

    for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
        assign chan[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel_ok = ({1'b0, i_Sel} < (SEL_W+1)'(NUM_IN));

    // Explicit select: valid of the addressed channel
    always_comb begin
        logic [SEL_W-1:0] kk;
        sel_hit = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            kk = SEL_W'(k);
            if (i_Sel == kk) sel_hit = i_valid[kk];
        end
    end

    // Round-robin: nearest valid channel at or after rr_q (last write wins)
    always_comb begin
        logic [SEL_W-1:0] kk;
        rr_gnt_vld = 1'b0;
        rr_gnt     = '0;
        for (int d = NUM_IN - 1; d >= 0; d--) begin
            for (int k = 0; k < NUM_IN; k++) begin
                kk = SEL_W'(k);
                if (i_valid[kk] && (k == (int'(rr_q) + d) % NUM_IN)) begin
                    rr_gnt_vld = 1'b1;
                    rr_gnt     = kk;
                end
            end
        end
    end

    assign gnt_vld = i_mode ? rr_gnt_vld : (sel_ok && sel_hit);
    assign gnt     = i_mode ? rr_gnt : i_Sel;
    assign xfer    = i_rst_n && gnt_vld && load_en;

    // Data of the granted channel and the one-hot accept
    always_comb begin
        logic [SEL_W-1:0] kk;
        gnt_data = '0;
        o_ready  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            kk = SEL_W'(k);
            if (gnt == kk) begin
                gnt_data    = chan[kk];
                o_ready[kk] = xfer;
            end
        end
    end

    // Pointer advances past a round-robin winner only
    always_comb begin
        rr_d = rr_q;
        if (xfer && i_mode) begin
            if (int'(gnt) == NUM_IN - 1) rr_d = '0;
            else                         rr_d = gnt + SEL_W'(1);
        end
    end

    assign sel_err_d = !i_mode && !sel_ok;

`ifdef MUX_NX1_SKID_EN
    assign load_en = !skid_vld_q;
    assign pop     = valid_q && i_ready;

    // Head register plus one skid entry, drained in FIFO order
    always_comb begin
        data_d      = data_q;
        src_d       = src_q;
        valid_d     = valid_q;
        skid_data_d = skid_data_q;
        skid_src_d  = skid_src_q;
        skid_vld_d  = skid_vld_q;
        if (skid_vld_q) begin
            if (pop) begin
                data_d     = skid_data_q;
                src_d      = skid_src_q;
                skid_vld_d = 1'b0;
            end
        end else if (valid_q) begin
            if (xfer && pop) begin
                data_d = gnt_data;
                src_d  = gnt;
            end else if (xfer) begin
                skid_data_d = gnt_data;
                skid_src_d  = gnt;
                skid_vld_d  = 1'b1;
            end else if (pop) begin
                valid_d = 1'b0;
            end
        end else if (xfer) begin
            data_d  = gnt_data;
            src_d   = gnt;
            valid_d = 1'b1;
        end
    end
`else
    assign load_en = !valid_q || i_ready;

    // Single output register: load, drain, or hold
    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = gnt_data;
            src_d   = gnt;
            valid_d = 1'b1;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end
`endif

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q      <= '0;
            src_q       <= '0;
            valid_q     <= 1'b0;
            sel_err_q   <= 1'b0;
            rr_q        <= '0;
`ifdef MUX_NX1_SKID_EN
            skid_data_q <= '0;
            skid_src_q  <= '0;
            skid_vld_q  <= 1'b0;
`endif
        end else begin
            data_q      <= data_d;
            src_q       <= src_d;
            valid_q     <= valid_d;
            sel_err_q   <= sel_err_d;
            rr_q        <= rr_d;
`ifdef MUX_NX1_SKID_EN
            skid_data_q <= skid_data_d;
            skid_src_q  <= skid_src_d;
            skid_vld_q  <= skid_vld_d;
`endif
        end
    end

    assign o_data    = data_q;
    assign o_src     = src_q;
    assign o_valid   = valid_q;
    assign o_sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// tb_mux_nx1_rr_reg: scoreboard bench for mux_nx1_rr_reg with NUM_IN=3.
// Queue model of the output path; monitor compares on the falling edge.
module tb_mux_nx1_rr_reg;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int SW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*DW-1:0] dat;
    logic [DW-1:0] ch [N];
    logic [N-1:0]  vld;
    logic [N-1:0]  rdy_o;
    logic          mode;
    logic [SW-1:0] sel;
    logic [DW-1:0] od;
    logic          ov;
    logic          ir;
    logic [SW-1:0] osrc;
    logic          oerr;

    ent_t q[$];
    int   rr;
    logic exp_err;
    bit   mon_en = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    ent_t pend;
    bit   pend_v   = 0;
    bit   pend_rst = 1;
    int   pend_rr  = 0;
    logic pend_err = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dat
        assign dat[k*DW +: DW] = ch[k];
    end

    mux_nx1_rr_reg #(
        .DATA_WIDTH(DW),
        .NUM_IN    (N)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_data   (dat),
        .i_valid  (vld),
        .o_ready  (rdy_o),
        .i_mode   (mode),
        .i_Sel    (sel),
        .o_data   (od),
        .o_valid  (ov),
        .i_ready  (ir),
        .o_src    (osrc),
        .o_sel_err(oerr)
    );

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    endfunction

    task automatic step(input logic m, input logic [SW-1:0] s,
                        input logic [N-1:0] v, input logic r,
                        input logic rn);
        int   g;
        int   k;
        bit   ld;
        logic [N-1:0] er;
        @(posedge clk);
        if (pend_rst) begin
            q.delete();
            rr      = 0;
            exp_err = 1'b0;
        end else begin
            if (pend_v) q.push_back(pend);
            rr      = pend_rr;
            exp_err = pend_err;
        end
        #1;
        rst_n = rn;
        mode  = m;
        sel   = s;
        vld   = v;
        ir    = r;
        for (int i = 0; i < N; i++) ch[i[SW-1:0]] = {$urandom, $urandom};
        #1;
`ifdef MUX_NX1_SKID_EN
        ld = (q.size() < 2);
`else
        ld = (q.size() == 0) || r;
`endif
        g = -1;
        if (!m) begin
            if (int'(s) < N) begin
                if (v[s]) g = int'(s);
            end
        end else begin
            for (int d = 0; d < N; d++) begin
                k = (rr + d) % N;
                if (g < 0 && v[k[SW-1:0]]) g = k;
            end
        end
        er = '0;
        if (rn && ld && g >= 0) er = N'(1) << g;
        chk("o_ready", 64'(rdy_o), 64'(er));
        pend_rst = !rn;
        pend_v   = rn && ld && (g >= 0);
        pend_err = !m && (int'(s) >= N);
        pend_rr  = rr;
        if (pend_v) begin
            pend.d = ch[g[SW-1:0]];
            pend.s = g[SW-1:0];
            if (m) pend_rr = (g + 1) % N;
        end
    endtask

    // Scoreboard monitor: output must match the head of the model queue
    always @(negedge clk) begin
        if (mon_en) begin
            chk("o_valid", 64'(ov), 64'(q.size() != 0));
            chk("o_sel_err", 64'(oerr), 64'(exp_err));
            if (ov && q.size() != 0) begin
                chk("o_data", 64'(od), 64'(q[0].d));
                chk("o_src", 64'(osrc), 64'(q[0].s));
                if (ir) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        sel   = '0;
        vld   = '0;
        ir    = 1'b0;
        for (int i = 0; i < N; i++) ch[i[SW-1:0]] = '0;

        step(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
        mon_en = 1;
        step(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 2'd0, 3'b000, 1'b1, 1'b1);
        @(negedge clk);
        chk("rst_o_data", 64'(od), 64'd0);
        chk("rst_o_src", 64'(osrc), 64'd0);

        step(1'b0, 2'd2, 3'b100, 1'b1, 1'b1);
        step(1'b0, 2'd0, 3'b000, 1'b1, 1'b1);

        for (int i = 0; i < 7; i++) step(1'b1, 2'd0, 3'b111, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 3'b101, 1'b1, 1'b1);

        step(1'b0, 2'd3, 3'b111, 1'b1, 1'b1);
        step(1'b0, 2'd0, 3'b000, 1'b1, 1'b1);
        step(1'b0, 2'd0, 3'b000, 1'b1, 1'b1);

        step(1'b1, 2'd0, 3'b111, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 3'b111, 1'b0, 1'b1);
        step(1'b1, 2'd0, 3'b111, 1'b1, 1'b1);
        step(1'b1, 2'd0, 3'b000, 1'b1, 1'b1);

        step(1'b1, 2'd0, 3'b111, 1'b1, 1'b1);
        step(1'b1, 2'd0, 3'b111, 1'b0, 1'b1);
        step(1'b1, 2'd0, 3'b111, 1'b0, 1'b0);
        step(1'b1, 2'd0, 3'b000, 1'b1, 1'b1);
        @(negedge clk);
        chk("stall_rst_o_data", 64'(od), 64'd0);
        chk("stall_rst_o_src", 64'(osrc), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 SW'($urandom_range(0, 3)),
                 N'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) != 0));
        end

        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 3'b000, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
